// File: rtl/uart_rx_fifo.sv
// Receive-side byte queue between the host UART and the ICE bus controller.
// Captures rx_latch strobes into a circular buffer drained by a valid/ready handshake.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int HIGH_WATER = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_latch,
    output logic [7:0]            out_char,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  almost_full,
    output logic                  overflow,
    output logic [7:0]            drop_count,
    input  logic                  overflow_clear
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] HIGH_CNT  = (DEPTH_LOG2 + 1)'(HIGH_WATER);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            drop_count_q, drop_count_d;

    logic full;
    logic pop;
    logic push;
    logic drop;

    assign full = (count_q == DEPTH_CNT);
    assign pop  = out_valid && out_ready;
    // A full queue still accepts a byte when the head leaves in the same cycle.
    assign push = rx_latch && (!full || pop);
    assign drop = rx_latch && full && !pop;

    assign out_valid   = (count_q != '0);
    assign almost_full = (count_q >= HIGH_CNT);
    assign out_char    = out_valid ? mem[rd_ptr_q] : 8'h00;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign drop_count  = drop_count_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (overflow_clear) begin
            overflow_d   = 1'b0;
            drop_count_d = 8'd0;
        end
        // A drop in the same cycle as a clear is counted against the cleared value.
        if (drop) begin
            overflow_d = 1'b1;
            if (overflow_clear) begin
                drop_count_d = 8'd1;
            end else if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr_q] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: one task per scenario.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_latch;
    logic [7:0] out_char;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       almost_full;
    logic       overflow;
    logic [7:0] drop_count;
    logic       overflow_clear;

    int checks = 0;
    int fails  = 0;

    uart_rx_fifo #(.DEPTH_LOG2(4), .HIGH_WATER(12)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_latch       (rx_latch),
        .out_char       (out_char),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .count          (count),
        .almost_full    (almost_full),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .overflow_clear (overflow_clear)
    );

    always #25 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        rx_data  = d;
        rx_latch = 1'b1;
        step();
        rx_latch = 1'b0;
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 16; i++) push_byte(base + 8'(i));
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_latch = 1'b0; rx_data = 8'h00; out_ready = 1'b0; overflow_clear = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        checks++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b expected 0", out_valid); end
        checks++; if (out_char !== 8'h00) begin fails++; $display("FAIL reset_char got %h expected 00", out_char); end
        checks++; if (almost_full !== 1'b0) begin fails++; $display("FAIL reset_af got %b expected 0", almost_full); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b expected 0", overflow); end
        checks++; if (drop_count !== 8'd0) begin fails++; $display("FAIL reset_drop got %0d expected 0", drop_count); end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (count !== 5'd0) begin fails++; $display("FAIL idle_ready_count cyc %0d got %0d expected 0", i, count); end
        end
        out_ready = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_single();
        push_byte(8'hA5);
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b expected 1", out_valid); end
        checks++; if (out_char !== 8'hA5) begin fails++; $display("FAIL single_char got %h expected a5", out_char); end
        checks++; if (count !== 5'd1) begin fails++; $display("FAIL single_count got %0d expected 1", count); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        checks++; if (count !== 5'd0) begin fails++; $display("FAIL single_pop_count got %0d expected 0", count); end
        checks++; if (out_char !== 8'h00) begin fails++; $display("FAIL single_pop_char got %h expected 00", out_char); end
        $display("test_single done");
    endtask

    task automatic test_fill_drain();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) begin
                push_byte(8'(i));
                checks++; if (count !== 5'(i + 1)) begin fails++; $display("FAIL fill_count r%0d i%0d got %0d expected %0d", r, i, count, i + 1); end
                checks++; if (almost_full !== (i + 1 >= 12)) begin fails++; $display("FAIL fill_af r%0d i%0d got %b expected %b", r, i, almost_full, (i + 1 >= 12)); end
            end
            out_ready = 1'b1;
            for (int i = 0; i < 16; i++) begin
                checks++; if (out_char !== 8'(i)) begin fails++; $display("FAIL drain_order r%0d i%0d got %h expected %h", r, i, out_char, 8'(i)); end
                step();
            end
            out_ready = 1'b0;
            checks++; if (count !== 5'd0) begin fails++; $display("FAIL drain_empty r%0d got %0d expected 0", r, count); end
            $display("test_fill_drain round %0d done", r);
        end
    endtask

    task automatic test_overflow();
        fill(8'h00);
        push_byte(8'h55); push_byte(8'h66); push_byte(8'h77);
        checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b expected 1", overflow); end
        checks++; if (drop_count !== 8'd3) begin fails++; $display("FAIL ovf_drop got %0d expected 3", drop_count); end
        checks++; if (out_char !== 8'h00) begin fails++; $display("FAIL ovf_head got %h expected 00", out_char); end
        checks++; if (count !== 5'd16) begin fails++; $display("FAIL ovf_count got %0d expected 16", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (out_char !== 8'(i)) begin fails++; $display("FAIL ovf_drain i%0d got %h expected %h", i, out_char, 8'(i)); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty got %b expected 0", out_valid); end
        overflow_clear = 1'b1; step(); overflow_clear = 1'b0;
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL clear_flag got %b expected 0", overflow); end
        checks++; if (drop_count !== 8'd0) begin fails++; $display("FAIL clear_drop got %0d expected 0", drop_count); end
        $display("test_overflow done");
    endtask

    task automatic test_full_pop();
        fill(8'h10);
        rx_data = 8'h99; rx_latch = 1'b1; out_ready = 1'b1;
        checks++; if (out_char !== 8'h10) begin fails++; $display("FAIL fullpop_head got %h expected 10", out_char); end
        step();
        rx_latch = 1'b0;
        checks++; if (count !== 5'd16) begin fails++; $display("FAIL fullpop_count got %0d expected 16", count); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL fullpop_ovf got %b expected 0", overflow); end
        for (int i = 1; i < 17; i++) begin
            logic [7:0] exp_c;
            exp_c = (i == 16) ? 8'h99 : 8'(8'h10 + i);
            checks++; if (out_char !== exp_c) begin fails++; $display("FAIL fullpop_drain i%0d got %h expected %h", i, out_char, exp_c); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (count !== 5'd0) begin fails++; $display("FAIL fullpop_empty got %0d expected 0", count); end
        $display("test_full_pop done");
    endtask

    task automatic test_saturate();
        fill(8'h20);
        rx_data = 8'hEE; rx_latch = 1'b1;
        for (int i = 0; i < 255; i++) step();
        checks++; if (drop_count !== 8'd255) begin fails++; $display("FAIL sat_reach got %0d expected 255", drop_count); end
        step();
        rx_latch = 1'b0;
        checks++; if (drop_count !== 8'd255) begin fails++; $display("FAIL sat_hold got %0d expected 255", drop_count); end
        checks++; if (out_char !== 8'h20) begin fails++; $display("FAIL sat_head got %h expected 20", out_char); end
        $display("test_saturate done");
    endtask

    task automatic test_clear_with_drop();
        rx_data = 8'hCC; rx_latch = 1'b1; overflow_clear = 1'b1;
        step();
        rx_latch = 1'b0; overflow_clear = 1'b0;
        checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL clrdrop_flag got %b expected 1", overflow); end
        checks++; if (drop_count !== 8'd1) begin fails++; $display("FAIL clrdrop_count got %0d expected 1", drop_count); end
        $display("test_clear_with_drop done");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) step();
        out_ready = 1'b0;
        checks++; if (count !== 5'd9) begin fails++; $display("FAIL mid_pre_count got %0d expected 9", count); end
        checks++; if (out_char !== 8'h27) begin fails++; $display("FAIL mid_pre_head got %h expected 27", out_char); end
        reset = 1'b1; rx_data = 8'h42; rx_latch = 1'b1; out_ready = 1'b1;
        step();
        reset = 1'b0; rx_latch = 1'b0; out_ready = 1'b0;
        checks++; if (count !== 5'd0) begin fails++; $display("FAIL mid_count got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got %b expected 0", out_valid); end
        checks++; if (out_char !== 8'h00) begin fails++; $display("FAIL mid_char got %h expected 00", out_char); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL mid_ovf got %b expected 0", overflow); end
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_byte(8'hB0 + 8'(i));
            checks++; if (count !== 5'd1) begin fails++; $display("FAIL b2b_count i%0d got %0d expected 1", i, count); end
            checks++; if (out_char !== 8'hB0 + 8'(i)) begin fails++; $display("FAIL b2b_char i%0d got %h expected %h", i, out_char, 8'hB0 + 8'(i)); end
        end
        step();
        out_ready = 1'b0;
        checks++; if (count !== 5'd0) begin fails++; $display("FAIL b2b_empty got %0d expected 0", count); end
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_overflow();
        test_full_pop();
        test_saturate();
        test_clear_with_drop();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
